// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue slice: datapath widths, ALU control
// codes, alu_op request codes and the issue FSM state encoding.
package alu_pkg;

  localparam int XLEN  = 32;
  localparam int RD_W  = 5;
  localparam int CNT_W = 2;

  typedef enum logic [2:0] {
    CTRL_ADD  = 3'b000,
    CTRL_SUB  = 3'b001,
    CTRL_AND  = 3'b010,
    CTRL_OR   = 3'b011,
    CTRL_NAND = 3'b100,
    CTRL_XOR  = 3'b101,
    CTRL_NOR  = 3'b110,
    CTRL_MUL  = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_ILL   = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EXEC     = 2'b01,
    ST_MUL_WAIT = 2'b10,
    ST_DONE     = 2'b11
  } state_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder. Maps alu_op and the instruction funct
// fields to a 3-bit ALU control code plus an illegal flag. Illegal requests
// report the add code so a rejected request can never look like a multiply.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       op5_i,
  output logic [2:0] code_o,
  output logic       illegal_o
);

  // Decode the request; nand/nor are never generated here.
  always_comb begin
    code_o    = CTRL_ADD;
    illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: code_o = CTRL_ADD;
      ALUOP_SUB: code_o = CTRL_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000: begin
            if (op5_i && (funct7_i == 7'b0000001)) begin
              code_o = CTRL_MUL;
            end else if (op5_i && funct7_i[5]) begin
              code_o = CTRL_SUB;
            end else begin
              code_o = CTRL_ADD;
            end
          end
          3'b111:  code_o = CTRL_AND;
          3'b110:  code_o = CTRL_OR;
          3'b100:  code_o = CTRL_XOR;
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage. Accepts one request at a time, drives the external
// combinational ALU for one EXEC cycle (plus MUL_LAT extra cycles for a
// multiply), captures the result and holds it in DONE until out_ready.
// DONE with out_ready can accept the next request directly into EXEC.
module alu_issue
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        op5,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [4:0]  rd,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              ill_q, ill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [RD_W-1:0]   ord_q, ord_d;
  logic              oill_q, oill_d;

  logic [2:0]        dec_code;
  logic              dec_ill;
  logic              accept;
  logic              drive_alu;

  alu_decoder u_dec (
    .alu_op_i  (alu_op),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .op5_i     (op5),
    .code_o    (dec_code),
    .illegal_o (dec_ill)
  );

  // Handshake and ALU drive; rst gates in_ready so nothing is offered in reset.
  always_comb begin
    in_ready  = rst && ((state_q == ST_IDLE) ||
                        ((state_q == ST_DONE) && out_ready));
    accept    = in_valid && in_ready;
    drive_alu = (state_q == ST_EXEC) || (state_q == ST_MUL_WAIT);
    alu_a     = drive_alu ? a_q    : '0;
    alu_b     = drive_alu ? b_q    : '0;
    alu_ctrl  = drive_alu ? ctrl_q : 3'b000;
    out_valid   = (state_q == ST_DONE);
    out_result  = res_q;
    out_rd      = ord_q;
    out_illegal = oill_q;
  end

  // Next-state logic: request capture, execute/wait sequencing, result capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ord_d   = ord_q;
    oill_d  = oill_q;

    if (accept) begin
      a_d    = src_a;
      b_d    = src_b;
      rd_d   = rd;
      ctrl_d = dec_code;
      ill_d  = dec_ill;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (ill_q) begin
          res_d   = '0;
          oill_d  = 1'b1;
          ord_d   = rd_q;
          state_d = ST_DONE;
        end else if ((ctrl_q == CTRL_MUL) && (MUL_LAT != 0)) begin
          cnt_d   = CNT_W'(MUL_LAT);
          state_d = ST_MUL_WAIT;
        end else begin
          res_d   = alu_result;
          oill_d  = 1'b0;
          ord_d   = rd_q;
          state_d = ST_DONE;
        end
      end
      ST_MUL_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 2'd1) begin
          res_d   = alu_result;
          oill_d  = 1'b0;
          ord_d   = rd_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = accept ? ST_EXEC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      ctrl_q  <= 3'b000;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      ord_q   <= '0;
      oill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ord_q   <= ord_d;
      oill_q  <= oill_d;
    end
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one parameter: MUL_LAT, default 1, the extra EXEC cycles a multiply holds operands stable (legal range 0..3).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  request present; in_ready  output  1  request accepted this edge when both high.
REQ-006 alu_op  input  2  00 add, 01 sub, 10 decode from funct fields, 11 illegal.
REQ-007 funct3  input  3; funct7  input  7; op5  input  1  (opcode bit 5, 1 = R-type).
REQ-008 src_a, src_b  input  32  operands; rd  input  5  destination tag.
REQ-009 alu_a, alu_b  output  32  operands driven to the external ALU; alu_ctrl  output  3  ALU control code.
REQ-010 alu_result  input  32  combinational result returned by the external ALU.
REQ-011 out_valid  output  1; out_ready  input  1  result handshake.
REQ-012 out_result  output  32; out_rd  output  5; out_illegal  output  1.

Function
REQ-013 ALU control codes SHALL be: 000 add, 001 sub, 010 and, 011 or, 100 nand, 101 xor, 110 nor, 111 mul.
REQ-014 Decode for alu_op=10: funct3=000 & funct7=0000001 & op5 -> mul; funct3=000 & funct7[5] & op5 -> sub; funct3=000 otherwise -> add; 111 -> and; 110 -> or; 100 -> xor; any other funct3 -> illegal.
REQ-015 alu_op=11 SHALL be illegal; nand/nor codes SHALL never be produced by decode.
REQ-016 States SHALL be IDLE, EXEC, MUL_WAIT, DONE.
REQ-017 IDLE: in_ready=1; on in_valid, register src_a, src_b, rd, decoded code, illegal flag; go EXEC.
REQ-018 EXEC (one cycle): alu_a/alu_b/alu_ctrl driven from registers; non-mul legal -> capture alu_result into out_result, go DONE; mul with MUL_LAT>0 -> load counter with MUL_LAT, go MUL_WAIT; mul with MUL_LAT=0 -> capture, go DONE.
REQ-019 MUL_WAIT: operands held stable; counter decrements each cycle; capture alu_result and go DONE on the edge where counter is 1.
REQ-020 Illegal request: skip ALU capture; at EXEC exit go DONE with out_result=0, out_illegal=1.
REQ-021 DONE: out_valid=1; out_result, out_rd, out_illegal held stable until out_ready.
REQ-022 in_ready SHALL also be 1 in DONE when out_ready=1; simultaneous completion and acceptance SHALL go directly to EXEC with new operands (no bubble).
REQ-023 DONE with out_ready=1 and in_valid=0 SHALL go IDLE; out_valid falls the next cycle.
REQ-024 Latency: accept edge E0 -> out_valid at E2 for non-mul/illegal, E2+MUL_LAT for mul.
REQ-025 alu_a/alu_b/alu_ctrl SHALL be 0 in IDLE and DONE.
REQ-026 Multiply result SHALL be the low 32 bits returned by the ALU; no width extension performed.

Reset
REQ-027 While rst=0: state IDLE, in_ready=0, out_valid=0, out_result=0, out_rd=0, out_illegal=0, alu_a/alu_b/alu_ctrl=0, counter=0.
REQ-028 Reset asserted mid-operation SHALL discard the in-flight request with no output handshake.
REQ-029 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-030 Shared package alu_pkg SHALL hold the 3-bit ALU control codes, the 2-bit alu_op codes, and the state enumeration.
REQ-031 Decode SHALL be a combinational sub-module alu_decoder (alu_op, funct3, funct7, op5 -> code, illegal); the ALU itself stays external.

Verification
REQ-032 Add: alu_op=00, A=5, B=7 -> out_valid at E2, out_result=12, out_illegal=0.
REQ-033 Sub via decode: alu_op=10, funct3=000, funct7=0100000, op5=1, A=3, B=5 -> out_result=0xFFFFFFFE.
REQ-034 Mul, MUL_LAT=2: funct7=0000001, A=0x10000, B=0x10001 -> alu_ctrl=111 stable 3 cycles, out_result=0x00010000 at E4.
REQ-035 Illegal: alu_op=10, funct3=001 -> out_illegal=1, out_result=0, alu_ctrl never 111.
REQ-036 Backpressure/back-to-back: out_ready=0 for 4 cycles then 1 with in_valid=1 -> outputs stable while stalled, second request enters EXEC same edge.
REQ-037 Reset mid-MUL_WAIT -> all outputs 0 immediately, no out_valid afterwards.
